lift53_row_stream: RTL and testbench
====================================

Name: lift53_row_stream

Overview:
- Streaming 1-D LeGall 5/3 lifting pass over one image row for the JPEG wavelet path.
- Successor to the single-sample lifting element; its combinational arithmetic is retained and generalised.
- Adds parametrised width, valid/ready streaming, an internal 3-sample window, row-length tracking, symmetric boundary extension and optional saturation.
- One instance performs one pass (predict or update, forward or inverse).
- Two instances chained form a full 1-D transform stage.

Parameters:
W, 16, sample width (signed two's complement)
MAX_LEN, 1024, maximum row length; sets counter width clog2(MAX_LEN+1)
SAT, 0, 0 = result wraps to W bits, 1 = result saturates to W-bit signed range

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
e_o_s  in  1  parity select: 0 = modify odd samples (predict), 1 = modify even samples (update); sampled at row start
f_i_s  in  1  0 = forward, 1 = inverse; sampled at row start
row_len  in  clog2(MAX_LEN+1)  samples in row; sampled with first sample of row
in_valid  in  1  input sample valid
in_ready  out  1  block accepts input this cycle
in_data  in  W  input sample x[i], signed
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_data  out  W  result sample y[i], signed
out_last  out  1  marks y[N-1] of the row

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, in_ready=0 in the reset cycle then 1; state IDLE; counters and window cleared.
- Reset mid-row discards all partial-row data; the next accepted sample is x[0] of a new row.
- Handshakes:
  - Input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
  - out_data/out_last are held stable while out_valid&!out_ready.
  - in_ready = (state!=FLUSH) & (!out_valid | out_ready).
- Window: registers L=x[i-1], C=x[i], R=x[i+1]. y[i] is computed and registered when x[i+1] is accepted (or in FLUSH for i=N-1).
- Latency: y[i] appears on out_data the cycle after x[i+1] is accepted. Sustained throughput is 1 sample/cycle with no bubbles inside a row.
- Boundary extension:
  - Left: x[-1]=x[1].
  - Right: x[N]=x[N-2].
  - N=0 is treated as N=1; N>MAX_LEN is clamped to MAX_LEN.
- Arithmetic, computed in W+2 bits, >>> is arithmetic shift:
  - Modified sample, predict (e_o_s=0, odd i): y = x[i] - ((l+r)>>>1) forward; y = x[i] + ((l+r)>>>1) inverse.
  - Modified sample, update (e_o_s=1, even i): y = x[i] + ((l+r+2)>>>2) forward; y = x[i] - ((l+r+2)>>>2) inverse.
  - Unmodified parity: y = x[i] exactly.
  - Result reduction: SAT=0 truncates to W LSBs; SAT=1 clamps to [-2^(W-1), 2^(W-1)-1].
- States:
  - IDLE: no sample held. On accept, latch row_len/e_o_s/f_i_s and store x[0]. If N=1, go to FLUSH; else go to FILL.
  - FILL: x[0] held. On accept of x[1], emit y[0] (left mirror). If N=2, go to FLUSH; else go to RUN.
  - RUN: each accept of x[i+1] emits y[i] and shifts the window. On accept of x[N-1], go to FLUSH.
  - FLUSH: in_ready=0. Emit y[N-1] (right mirror) with out_last=1 once the output register is free, then go to IDLE.
  - N=1: y[0]=x[0] unmodified, out_last=1.
- Row parameters are frozen for the whole row; changes on e_o_s/f_i_s/row_len mid-row are ignored.
- Back-to-back rows: x[0] of the next row may be accepted in the same cycle y[N-1] transfers out (IDLE entered that cycle).

Test Plan:
- Forward predict, e_o_s=0, f_i_s=0, N=4, in [215,216,217,218] -> out [215,0,217,1], out_last on 4th sample; y[1] valid 1 cycle after x[2] accepted.
- Forward update, e_o_s=1, f_i_s=0, N=4, in [215,0,217,1] -> out [215,0,217,1]. Inverse predict, e_o_s=0, f_i_s=1, on [215,0,217,1] -> [215,216,217,218] (perfect reconstruction).
- Overflow, W=16, forward predict, N=3, in [-32768,32767,-32768] -> y[1]=-1 with SAT=0; y[1]=32767 with SAT=1.
- Backpressure: out_ready toggled 1,0,0,1,... over a 16-sample ramp -> no sample lost or duplicated, out_data stable while stalled, in_ready=0 whenever out_valid&!out_ready.
- Edge rows: N=1 in [5] -> [5] with out_last. N=2, forward predict, in [10,20] -> [10,10]. N=0 is handled as N=1.
- rst asserted after 3 of 8 samples -> out_valid=0 next cycle. A fresh 4-sample row afterwards produces the correct 4 outputs, with no residue from the aborted row.

Source files
------------

// File: rtl/lift53_row_stream.sv
// One streaming LeGall 5/3 lifting pass (predict or update, forward or inverse) over an image row,
// with a 3-sample window, symmetric boundary extension and optional saturation.
module lift53_row_stream #(
    parameter int W       = 16,
    parameter int MAX_LEN = 1024,
    parameter int SAT     = 0,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          e_o_s,
    input  logic          f_i_s,
    input  logic [CW-1:0] row_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] len_q, cnt_q, len_eff, cnt_inc;
    logic          eos_q, fis_q, par_q;
    logic [W-1:0]  l_q, c_q;
    logic          out_vld_q, out_last_q;
    logic [W-1:0]  out_data_q;

    logic          out_free, acc, emit, emit_last;
    logic [W-1:0]  lift_l, lift_c, lift_r, res;
    logic          lift_mod, lift_sub;
    logic signed [W+1:0] l_x, c_x, r_x, sum, adj, y_x;

    assign out_free  = !out_vld_q || out_ready;
    assign in_ready  = !rst && (state_q != FLUSH) && out_free;
    assign acc       = in_valid && in_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        len_eff = row_len;
        if (row_len == '0)
            len_eff = CW'(1);
        else if (row_len > CW'(MAX_LEN))
            len_eff = CW'(MAX_LEN);
    end

    // Window operands: left mirror in FILL (x[-1]=x[1]), right mirror in FLUSH (x[N]=x[N-2]).
    always_comb begin
        lift_l   = l_q;
        lift_c   = c_q;
        lift_r   = in_data;
        lift_mod = par_q ^ eos_q;
        if (state_q == FILL)
            lift_l = in_data;
        if (state_q == FLUSH) begin
            lift_r = l_q;
            if (len_q == CW'(1))
                lift_mod = 1'b0;
        end
    end

    always_comb begin
        l_x      = {{2{lift_l[W-1]}}, lift_l};
        c_x      = {{2{lift_c[W-1]}}, lift_c};
        r_x      = {{2{lift_r[W-1]}}, lift_r};
        sum      = l_x + r_x;
        adj      = eos_q ? ((sum + (W+2)'(2)) >>> 2) : (sum >>> 1);
        lift_sub = !(eos_q ^ fis_q);
        y_x      = lift_sub ? (c_x - adj) : (c_x + adj);
        if (!lift_mod)
            y_x = c_x;
        res = y_x[W-1:0];
        if (SAT != 0 && y_x[W+1:W-1] != 3'b000 && y_x[W+1:W-1] != 3'b111)
            res = y_x[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (acc) state_d = (len_eff == CW'(1)) ? FLUSH : FILL;
            FILL:  if (acc) state_d = (len_q == CW'(2)) ? FLUSH : RUN;
            RUN:   if (acc && cnt_inc == len_q) state_d = FLUSH;
            FLUSH: if (out_free) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        emit      = 1'b0;
        emit_last = 1'b0;
        case (state_q)
            FILL, RUN: emit = acc;
            FLUSH: begin
                emit      = out_free;
                emit_last = 1'b1;
            end
            default: emit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            cnt_q      <= '0;
            eos_q      <= 1'b0;
            fis_q      <= 1'b0;
            par_q      <= 1'b0;
            l_q        <= '0;
            c_q        <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            if (acc && state_q == IDLE) begin
                len_q <= len_eff;
                eos_q <= e_o_s;
                fis_q <= f_i_s;
                c_q   <= in_data;
                cnt_q <= CW'(1);
                par_q <= 1'b0;
            end else if (acc) begin
                l_q   <= c_q;
                c_q   <= in_data;
                cnt_q <= cnt_inc;
                par_q <= !par_q;
            end
            if (emit) begin
                out_vld_q  <= 1'b1;
                out_data_q <= res;
                out_last_q <= emit_last;
            end else if (out_ready) begin
                out_vld_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lift53_row_stream.sv
// Directed table-driven bench for lift53_row_stream; a SAT=1 twin shares the inputs.
module tb_lift53_row_stream;
    localparam int W  = 16;
    localparam int ML = 16;
    localparam int CW = $clog2(ML + 1);

    logic clk = 1'b0;
    logic rst, e_o_s, f_i_s, in_valid, out_ready;
    logic [CW-1:0] row_len;
    logic signed [W-1:0] in_data;
    logic in_ready, out_valid, out_last, s_in_ready, s_out_valid, s_out_last;
    logic signed [W-1:0] out_data, s_out_data;

    always #5 clk = ~clk;

    lift53_row_stream #(.W(W), .MAX_LEN(ML), .SAT(0)) dut (
        .clk(clk), .rst(rst), .e_o_s(e_o_s), .f_i_s(f_i_s), .row_len(row_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

    lift53_row_stream #(.W(W), .MAX_LEN(ML), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .e_o_s(e_o_s), .f_i_s(f_i_s), .row_len(row_len),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_last(s_out_last));

    typedef struct packed {
        logic             eos;
        logic             fis;
        logic [7:0]       len;
        logic [7:0]       n;
        logic             bp;
        logic [15:0][15:0] x;
        logic [15:0][15:0] y;
        logic [15:0][15:0] ys;
    } vec_t;

    vec_t vt[$];
    int   xq[$], yq[$];
    int   errs = 0, checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit eos, input bit fis, input int len, input int n, input bit bp,
                           input int sat_idx, input int sat_val);
        vec_t v;
        v = '0;
        v.eos = eos; v.fis = fis; v.len = 8'(len); v.n = 8'(n); v.bp = bp;
        for (int k = 0; k < n; k++) begin
            v.x[k] = 16'(xq[k]);
            v.y[k] = 16'(yq[k]);
        end
        v.ys = v.y;
        if (sat_idx >= 0) v.ys[sat_idx] = 16'(sat_val);
        vt.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int sent, got, t, n;
        int acc_t[16], out_t[16];
        logic [W-1:0] prev_d;
        logic prev_l, stalled;
        sent = 0; got = 0; t = 0; stalled = 1'b0; n = int'(v.n);
        prev_d = '0; prev_l = 1'b0;
        while (got < n && t < 400) begin
            @(negedge clk);
            out_ready = v.bp ? (t % 4 == 0 || t % 4 == 3) : 1'b1;
            in_valid  = (sent < n);
            in_data   = (sent < n) ? $signed(v.x[sent]) : '0;
            // Row parameters are only valid with x[0]; afterwards drive junk to prove they are frozen.
            e_o_s   = (sent == 0) ? v.eos : !v.eos;
            f_i_s   = (sent == 0) ? v.fis : !v.fis;
            row_len = (sent == 0) ? CW'(v.len) : '0;
            #1;
            if (stalled) begin
                chk($sformatf("v%0d hold_data", vi), int'(out_data), int'($signed(prev_d)));
                chk($sformatf("v%0d hold_last", vi), int'(out_last), int'(prev_l));
            end
            if (out_valid && !out_ready)
                chk($sformatf("v%0d stall_in_ready", vi), int'(in_ready), 0);
            if (in_valid && in_ready) begin
                acc_t[sent] = t;
                sent++;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("v%0d y%0d", vi, got), int'(out_data), int'($signed(v.y[got])));
                chk($sformatf("v%0d sat_y%0d", vi, got), int'(s_out_data), int'($signed(v.ys[got])));
                chk($sformatf("v%0d last%0d", vi, got), int'(out_last), int'(got == n - 1));
                out_t[got] = t;
                got++;
            end
            stalled = out_valid && !out_ready;
            prev_d  = out_data;
            prev_l  = out_last;
            t++;
        end
        in_valid = 1'b0;
        chk($sformatf("v%0d outputs_seen", vi), got, n);
        if (!v.bp && got == n)
            for (int i = 0; i < n - 1; i++)
                chk($sformatf("v%0d latency%0d", vi, i), out_t[i], acc_t[i+1] + 1);
    endtask

    initial begin
        int sent, got, t;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        e_o_s = 1'b0; f_i_s = 1'b0; row_len = '0;

        xq = '{215, 216, 217, 218};   yq = '{215, 0, 217, 1};       add_vec(0, 0, 4, 4, 0, -1, 0);
        xq = '{215, 0, 217, 1};       yq = '{215, 0, 217, 1};       add_vec(1, 0, 4, 4, 0, -1, 0);
        xq = '{215, 0, 217, 1};       yq = '{215, 216, 217, 218};   add_vec(0, 1, 4, 4, 0, -1, 0);
        xq = '{-32768, 32767, -32768}; yq = '{-32768, -1, -32768};  add_vec(0, 0, 3, 3, 0, 1, 32767);
        xq = '{5};                    yq = '{5};                    add_vec(0, 0, 1, 1, 0, -1, 0);
        xq = '{10, 20};               yq = '{10, 10};               add_vec(0, 0, 2, 2, 0, -1, 0);
        xq = '{7};                    yq = '{7};                    add_vec(1, 0, 0, 1, 0, -1, 0);
        xq = '{-7, 4, -3, 10, 6};     yq = '{-9, 4, -7, 10, 1};     add_vec(1, 1, 5, 5, 0, -1, 0);
        xq = '{-5, 0, -2};            yq = '{-5, 4, -2};            add_vec(0, 0, 3, 3, 0, -1, 0);
        xq.delete(); yq.delete();
        for (int i = 0; i < 16; i++) begin
            xq.push_back(3 * i);
            yq.push_back((i % 2 == 1) ? ((i == 15) ? 3 : 0) : 3 * i);
        end
        add_vec(0, 0, 16, 16, 1, -1, 0);
        yq = '{2, 3, 9, 9, 18, 15, 27, 21, 36, 27, 45, 33, 54, 39, 63, 45};
        add_vec(1, 0, 20, 16, 1, -1, 0);

        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        foreach (vt[i]) run_vec(vt[i], i);

        // Back-to-back single-sample rows: next x[0] accepted while the previous y transfers.
        sent = 0; got = 0; t = 0;
        while (got < 3 && t < 40) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (sent < 3);
            in_data = 16'(sent + 1);
            e_o_s = 1'b1; f_i_s = 1'b0; row_len = CW'(1);
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("b2b y%0d", got), int'(out_data), got + 1);
                chk($sformatf("b2b last%0d", got), int'(out_last), 1);
                if (got < 2) chk($sformatf("b2b in_ready%0d", got), int'(in_ready), 1);
                got++;
            end
            t++;
        end
        in_valid = 1'b0;
        chk("b2b outputs_seen", got, 3);

        // Abort an 8-sample row after 3 samples, then a fresh row must be clean.
        sent = 0; t = 0;
        while (sent < 3 && t < 40) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1; in_data = 16'(100 + 7 * sent);
            e_o_s = 1'b0; f_i_s = 1'b0; row_len = CW'(8);
            #1;
            if (in_ready) sent++;
            t++;
        end
        chk("abort samples_sent", sent, 3);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort in_ready", int'(in_ready), 0);
        rst = 1'b0;
        run_vec(vt[0], 100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
